// File: rtl/memoria_resp.sv
// Unified 64-byte responder for polirv: clear sweep, byte loader, then CPU fetch/load/store.
// Define MEM_GUARD_EN to suppress CPU writes touching bytes below GUARD_LIMIT.
module memoria_resp #(
  parameter int ADDR_W = 6,
`ifdef MEM_GUARD_EN
  parameter int GUARD_LIMIT = 32,
`endif
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [31:0]       i_mem_data,
  input  logic              d_mem_we,
  input  logic [ADDR_W-1:0] d_mem_addr,
  inout  wire  [63:0]       d_mem_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              mem_ready,
  output logic              guard_fault
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic [7:0]        mem_q [DEPTH];
  logic              run;
  logic              cpu_wr_en;
  logic [31:0]       i_word;
  logic [63:0]       d_word;

  assign run = (state_reg == ST_RUN);

`ifdef MEM_GUARD_EN
  logic guard_hit;
  logic guard_fault_reg;

  always_comb begin
    guard_hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (int'(d_mem_addr + ADDR_W'(k)) < GUARD_LIMIT) guard_hit = 1'b1;
    end
  end

  assign cpu_wr_en = run && d_mem_we && !guard_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          guard_fault_reg <= 1'b0;
    else if (run && d_mem_we && guard_hit) guard_fault_reg <= 1'b1;
  end

  assign guard_fault = guard_fault_reg;
`else
  assign cpu_wr_en   = run && d_mem_we;
  assign guard_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_CLEAR;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          cnt_reg <= cnt_reg + ADDR_W'(1);
          if (cnt_reg == ADDR_W'(DEPTH - 1)) state_reg <= ST_LOAD;
        end
        ST_LOAD: if (ld_valid && ld_last) state_reg <= ST_RUN;
        ST_RUN:  state_reg <= ST_RUN;
        default: state_reg <= ST_CLEAR;
      endcase
    end
  end

  // Each byte decides independently whether it lies inside the 8-byte write window (wrapping).
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_byte
      logic [7:0]        byte_reg;
      logic [ADDR_W-1:0] off;

      assign off       = ADDR_W'(gi) - d_mem_addr;
      assign mem_q[gi] = byte_reg;

      always_ff @(posedge clk) begin
        if (state_reg == ST_CLEAR && cnt_reg == ADDR_W'(gi))
          byte_reg <= 8'h00;
        else if (state_reg == ST_LOAD && ld_valid && ld_addr == ADDR_W'(gi))
          byte_reg <= ld_data;
        else if (cpu_wr_en && off[ADDR_W-1:3] == '0)
          byte_reg <= d_mem_data[{off[2:0], 3'b000} +: 8];
      end
    end
  endgenerate

  always_comb begin
    i_word = '0;
    d_word = '0;
    for (int k = 0; k < 4; k++) i_word[8*k +: 8] = mem_q[i_mem_addr + ADDR_W'(k)];
    for (int k = 0; k < 8; k++) d_word[8*k +: 8] = mem_q[d_mem_addr + ADDR_W'(k)];
  end

  assign i_mem_data = run ? i_word : NOP_INSTR;
  assign d_mem_data = d_mem_we ? 64'bz : (run ? d_word : 64'h0);
  assign ld_ready   = (state_reg == ST_LOAD);
  assign mem_ready  = run;

endmodule

// File: tb/tb_memoria_resp.sv
// Directed bench for memoria_resp with a byte-array reference model checked every negedge.
module tb_memoria_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  i_mem_addr;
  logic [31:0] i_mem_data;
  logic        d_mem_we;
  logic [5:0]  d_mem_addr;
  wire  [63:0] d_mem_data;
  logic [63:0] cpu_wdata;
  logic        ld_valid;
  logic        ld_ready;
  logic [5:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        mem_ready;
  logic        guard_fault;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  assign d_mem_data = d_mem_we ? cpu_wdata : 64'bz;

  memoria_resp dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
    .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr), .d_mem_data(d_mem_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last),
    .mem_ready(mem_ready), .guard_fault(guard_fault)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = sweeping, 1 = loading, 2 = serving the CPU.
  logic [7:0] m_mem [64];
  int         m_phase = 0;
  int         m_since = 0;
  logic       m_fault = 1'b0;

  function automatic bit guard_blocks(input logic [5:0] a);
`ifdef MEM_GUARD_EN
    for (int k = 0; k < 8; k++) if (((int'(a) + k) % 64) < 32) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_read(input logic [5:0] a, input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = m_mem[(int'(a) + k) % 64];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_since <= 0;
      m_fault <= 1'b0;
    end else if (m_phase == 0) begin
      // After 64 sweep cycles the whole array is known to be zero.
      m_since <= m_since + 1;
      if (m_since == 63) begin
        for (int k = 0; k < 64; k++) m_mem[k] <= 8'h00;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (ld_valid) begin
        m_mem[ld_addr] <= ld_data;
        if (ld_last) m_phase <= 2;
      end
    end else if (d_mem_we) begin
      if (guard_blocks(d_mem_addr)) m_fault <= 1'b1;
      else for (int k = 0; k < 8; k++) m_mem[(int'(d_mem_addr) + k) % 64] <= cpu_wdata[8*k +: 8];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [63:0] ei;
      logic [63:0] ed;
      ei = (m_phase == 2) ? m_read(i_mem_addr, 4) : 64'h13;
      if (d_mem_we)          ed = cpu_wdata;
      else if (m_phase == 2) ed = m_read(d_mem_addr, 8);
      else                   ed = 64'h0;
      check("mdl_mem_ready", {63'h0, mem_ready}, {63'h0, m_phase == 2});
      check("mdl_ld_ready", {63'h0, ld_ready}, {63'h0, m_phase == 1});
      check("mdl_guard_fault", {63'h0, guard_fault}, {63'h0, m_fault});
      check("mdl_i_mem_data", {32'h0, i_mem_data}, ei);
      check("mdl_d_mem_data", d_mem_data, ed);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ld_ready();
    int c = 0;
    while (!ld_ready && c < 200) begin
      tick();
      c++;
    end
    check("clear_cycles", 64'(c), 64'd64);
    $display("sweep done after %0d cycles", c);
  endtask

  task automatic load_byte(input logic [5:0] a, input logic [7:0] d, input logic last);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    $display("load byte %02h at %0d last=%0b", d, a, last);
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [63:0] v);
    d_mem_addr = a; cpu_wdata = v; d_mem_we = 1'b1;
    tick();
    d_mem_we = 1'b0;
    #1;
    $display("cpu write %h at %0d", v, a);
  endtask

  task automatic d_read_chk(input string name, input logic [5:0] a, input logic [63:0] exp);
    d_mem_addr = a;
    #1;
    check(name, d_mem_data, exp);
    $display("data read at %0d -> %h", a, d_mem_data);
  endtask

  task automatic i_read_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    i_mem_addr = a;
    #1;
    check(name, {32'h0, i_mem_data}, {32'h0, exp});
    $display("instr read at %0d -> %h", a, i_mem_data);
  endtask

  initial begin
    i_mem_addr = '0; d_mem_addr = '0; d_mem_we = 1'b0; cpu_wdata = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) tick();
    check("rst_mem_ready", {63'h0, mem_ready}, 64'h0);
    check("rst_ld_ready", {63'h0, ld_ready}, 64'h0);
    check("rst_nop", {32'h0, i_mem_data}, 64'h13);
    rst_n = 1'b1;
    wait_ld_ready();

    load_byte(6'd0, 8'h13, 1'b0);
    load_byte(6'd1, 8'h00, 1'b0);
    load_byte(6'd2, 8'h50, 1'b0);
    load_byte(6'd3, 8'h00, 1'b1);
    check("load_done_ld_ready", {63'h0, ld_ready}, 64'h0);
    check("load_done_mem_ready", {63'h0, mem_ready}, 64'h1);
    i_read_chk("fetch_addi", 6'd0, 32'h00500013);
    for (int a = 8; a < 64; a += 8) begin
      d_mem_addr = 6'(a);
      tick();
      check("swept_zero", d_mem_data, 64'h0);
    end

    // Wrapping store at the top of the array; the same-cycle read must see old bytes.
    i_mem_addr = 6'd60; d_mem_addr = 6'd60; cpu_wdata = 64'h1122334455667788; d_mem_we = 1'b1;
    #1;
    check("bus_released", d_mem_data, 64'h1122334455667788);
    check("rdw_old_data", {32'h0, i_mem_data}, 64'h0);
    tick();
    d_mem_we = 1'b0;
    #1;
    $display("cpu write 1122334455667788 at 60");
`ifdef MEM_GUARD_EN
    check("guard_wrap_fault", {63'h0, guard_fault}, 64'h1);
    d_read_chk("guard_wrap_kept", 6'd60, 64'h0050001300000000);
`else
    i_read_chk("wrap_hi", 6'd60, 32'h55667788);
    i_read_chk("wrap_lo", 6'd0, 32'h11223344);
    d_read_chk("wrap_read", 6'd60, 64'h1122334455667788);
    cpu_write(6'd5, 64'hDEADBEEFCAFEF00D);
    d_read_chk("unaligned_read", 6'd4, 64'hADBEEFCAFEF00D00);
`endif
    tick();

    // Reset in the middle of loading discards everything loaded so far.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ld_ready();
    load_byte(6'd0, 8'hAA, 1'b0);
    load_byte(6'd1, 8'hBB, 1'b0);
    check("mid_load_ld_ready", {63'h0, ld_ready}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_ready", {63'h0, mem_ready}, 64'h0);
    check("abort_ld_ready", {63'h0, ld_ready}, 64'h0);
    tick();
    rst_n = 1'b1;
    wait_ld_ready();
    load_byte(6'd40, 8'h5A, 1'b1);
    i_read_chk("reload_zero", 6'd0, 32'h0);
    d_read_chk("reload_byte", 6'd40, 64'h5A);
    check("fault_cleared", {63'h0, guard_fault}, 64'h0);

    cpu_write(6'd28, 64'h0102030405060708);
`ifdef MEM_GUARD_EN
    check("guard_fault_set", {63'h0, guard_fault}, 64'h1);
    d_read_chk("guard_kept", 6'd28, 64'h0);
`else
    check("no_guard_fault", {63'h0, guard_fault}, 64'h0);
    d_read_chk("write_28", 6'd28, 64'h0102030405060708);
`endif
    cpu_write(6'd32, 64'hA1A2A3A4A5A6A7A8);
    d_read_chk("write_32", 6'd32, 64'hA1A2A3A4A5A6A7A8);
`ifdef MEM_GUARD_EN
    check("guard_sticky", {63'h0, guard_fault}, 64'h1);
`else
    check("guard_zero", {63'h0, guard_fault}, 64'h0);
`endif
    repeat (2) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memoria_resp.md
Name: memoria_resp

Overview:
- Memory-side responder for the polirv instruction and data interface.
- Holds a unified 64-byte little-endian array that serves 32-bit instruction fetches and 64-bit data loads and stores.
- After reset it runs a clear sweep, then a byte-wise program load handshake, then normal CPU service.
- Outputs mem_ready so the top level can hold polirv in reset until the program is loaded.

Parameters:
ADDR_W, 6, byte address width; array depth is 2**ADDR_W bytes
NOP_INSTR, 32'h00000013, instruction word returned while not in RUN (ADDI x0,x0,0)
GUARD_LIMIT, 32, first writable byte address when MEM_GUARD_EN is defined

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
i_mem_addr  input  ADDR_W  instruction byte address
i_mem_data  output  32  instruction word
d_mem_we  input  1  data write enable from CPU
d_mem_addr  input  ADDR_W  data byte address
d_mem_data  inout  64  data bus: memory drives it when d_mem_we=0, CPU drives it when d_mem_we=1
ld_valid  input  1  loader byte valid
ld_ready  output  1  loader byte accepted this cycle
ld_addr  input  ADDR_W  loader byte address
ld_data  input  8  loader byte
ld_last  input  1  final loader byte; qualified by ld_valid
mem_ready  output  1  array is in RUN and serves the CPU
guard_fault  output  1  sticky illegal-write flag; tied 0 when MEM_GUARD_EN is undefined

Behaviour:
- Reset (async, rst_n=0):
  - state=CLEAR, cnt=0.
  - mem_ready=0, ld_ready=0, guard_fault=0.
  - Array contents are not reset directly; the CLEAR sweep zeroes them.
- State CLEAR:
  - Each clock writes byte[cnt]=0 and increments cnt.
  - When cnt=2**ADDR_W-1, that byte is written, cnt wraps to 0, and next state=LOAD.
  - Duration is exactly 64 cycles at default ADDR_W.
  - ld_valid and d_mem_we are ignored.
- State LOAD:
  - ld_ready=1 (registered, asserted from the first LOAD cycle).
  - On ld_valid and ld_ready at a clock edge, byte[ld_addr]=ld_data.
  - If ld_last is also set, next state=RUN and ld_ready drops the following cycle.
  - d_mem_we is ignored.
- State RUN:
  - mem_ready=1, ld_ready=0; ld_valid is ignored.
  - RUN is left only by reset.
- Instruction read:
  - Combinational.
  - In RUN, i_mem_data = {byte[a+3], byte[a+2], byte[a+1], byte[a]} with a=i_mem_addr.
  - Every index is taken modulo 2**ADDR_W, so addresses wrap past the top of the array.
  - Outside RUN, i_mem_data=NOP_INSTR.
- Data read:
  - Combinational, when d_mem_we=0: d_mem_data = bytes d_mem_addr..d_mem_addr+7, little-endian, same modulo wrap.
  - Outside RUN the memory drives 64'h0.
  - When d_mem_we=1, d_mem_data is high-Z from this block in every state.
- Data write:
  - In RUN with d_mem_we=1, all 8 bytes are written at the clock edge, little-endian, with modulo wrap.
  - Unaligned addresses are legal.
- Read-during-write: same-cycle reads of written bytes return the old contents; new data is visible the cycle after the edge.
- Reset mid-operation: rst_n low in any state returns immediately to CLEAR; a full re-sweep and re-load are required.
- Simultaneous loader and CPU writes cannot collide, because the states are mutually exclusive.

Optional Feature:
- Macro: MEM_GUARD_EN.
- Defined:
  - In RUN, a CPU write is suppressed entirely (no bytes written) if any of its 8 target byte indices, after wrap, is below GUARD_LIMIT.
  - guard_fault is set the cycle after a suppressed write and stays set until reset.
  - Loader writes are never guarded.
- Undefined: no write protection and guard_fault is constant 0.

Test Plan:
- Reset release, no loader activity -> mem_ready=0, i_mem_data=32'h00000013 throughout, ld_ready rises exactly 64 clocks after reset release, and every byte reads 0 after RUN is reached.
- Load bytes 13,00,50,00 to addresses 0..3 with ld_last on the fourth -> ld_ready=0 and mem_ready=1 the next cycle; i_mem_addr=0 gives i_mem_data=32'h00500013.
- In RUN, write 64'h1122334455667788 at d_mem_addr=60 -> bytes 60..63 hold 88,77,66,55 and bytes 0..3 hold 44,33,22,11; reading at 60 returns the same value.
- d_mem_we=1 -> d_mem_data undriven by the memory (bench driver value unchanged); d_mem_we=0 -> memory drives stored data; reading during the write cycle returns old data.
- Assert rst_n low during LOAD after 2 bytes -> mem_ready=0 and ld_ready=0 immediately; after a new 64-cycle sweep the two previously loaded bytes read 0.
- With MEM_GUARD_EN defined, write at d_mem_addr=28 in RUN -> bytes unchanged and guard_fault=1 the next cycle; a subsequent write at 32 succeeds and guard_fault stays 1.
